// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one LCD character-write port between clients A and B.
// The winner's row/column/char are latched at grant and held until the driver acks or the watchdog fires.
module lcd_arbiter #(
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       row_a,
   input  logic [5:0] col_a,
   input  logic [7:0] char_a,
   output logic       ack_a,
   output logic       err_a,
   input  logic       req_b,
   input  logic       row_b,
   input  logic [5:0] col_b,
   input  logic [7:0] char_b,
   output logic       ack_b,
   output logic       err_b,
   output logic       rq_lcd,
   input  logic       ack_lcd,
   output logic       lcd_row,
   output logic [5:0] lcd_column,
   output logic [7:0] lcd_char,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
   typedef enum logic {CLIENT_A, CLIENT_B} client_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state, state_nxt;
   client_t         owner, owner_nxt;
   client_t         last_grant, last_grant_nxt;
   client_t         winner;
   logic [TO_W-1:0] cnt, cnt_nxt;
   logic            rq_nxt, row_nxt, busy_nxt;
   logic [5:0]      col_nxt;
   logic [7:0]      char_nxt;
   logic            ack_a_nxt, ack_b_nxt, err_a_nxt, err_b_nxt;
   logic            finish, abort;

   // On a tie the client that did not win last time goes next.
   always_comb begin
      if (req_a && req_b) winner = (last_grant == CLIENT_A) ? CLIENT_B : CLIENT_A;
      else                winner = req_b ? CLIENT_B : CLIENT_A;
   end

   // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      rq_nxt         = rq_lcd;
      row_nxt        = lcd_row;
      col_nxt        = lcd_column;
      char_nxt       = lcd_char;
      ack_a_nxt      = 1'b0;
      ack_b_nxt      = 1'b0;
      err_a_nxt      = 1'b0;
      err_b_nxt      = 1'b0;
      finish         = 1'b0;
      abort          = 1'b0;

      unique case (state)
         IDLE: begin
            if (req_a || req_b) begin
               owner_nxt = winner;
               row_nxt   = (winner == CLIENT_B) ? row_b  : row_a;
               col_nxt   = (winner == CLIENT_B) ? col_b  : col_a;
               char_nxt  = (winner == CLIENT_B) ? char_b : char_a;
               rq_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = cnt + 1'b1;
            // A driver ack on the timeout cycle still counts as success.
            if (ack_lcd) begin
               finish = 1'b1;
            end else if (cnt == TO_LAST) begin
               finish = 1'b1;
               abort  = 1'b1;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (finish) begin
         rq_nxt         = 1'b0;
         ack_a_nxt      = (owner == CLIENT_A);
         ack_b_nxt      = (owner == CLIENT_B);
         err_a_nxt      = abort && (owner == CLIENT_A);
         err_b_nxt      = abort && (owner == CLIENT_B);
         last_grant_nxt = owner;
         state_nxt      = GAP;
      end

      busy_nxt = (state_nxt != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= CLIENT_A;
         last_grant <= CLIENT_B;
         cnt        <= '0;
         rq_lcd     <= 1'b0;
         lcd_row    <= 1'b0;
         lcd_column <= '0;
         lcd_char   <= 8'h20;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         err_a      <= 1'b0;
         err_b      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         cnt        <= cnt_nxt;
         rq_lcd     <= rq_nxt;
         lcd_row    <= row_nxt;
         lcd_column <= col_nxt;
         lcd_char   <= char_nxt;
         ack_a      <= ack_a_nxt;
         ack_b      <= ack_b_nxt;
         err_a      <= err_a_nxt;
         err_b      <= err_b_nxt;
         busy       <= busy_nxt;
      end
   end

endmodule

// File: doc/lcd_arbiter.md
Name: lcd_arbiter

Overview:
Two-client arbiter sharing the single LCD character-write port (rq_lcd/ack_lcd plus row/column/char) between requesters A and B. It grants round-robin and latches the winner's row, column and char at grant. It holds rq_lcd until the LCD driver acks, then returns a one-cycle ack to the winning client. A watchdog aborts transactions the driver never acks.

Parameters:
TIMEOUT, 1023, max cycles in BUSY without ack_lcd before abort (must be >= 1 and fit in TO_W bits).
TO_W, 10, width of the watchdog counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
req_a  input  1  client A request, level; held until ack_a
row_a  input  1  client A row, stable while req_a=1
col_a  input  6  client A column
char_a  input  8  client A character code
ack_a  output  1  one-cycle pulse: A's transaction finished
err_a  output  1  one-cycle pulse with ack_a: A's transaction aborted by timeout
req_b, row_b, col_b, char_b, ack_b, err_b  same as A, for client B
rq_lcd  output  1  request to LCD driver, level
ack_lcd  input  1  LCD driver acknowledge, one-cycle pulse
lcd_row  output  1  latched row
lcd_column  output  6  latched column
lcd_char  output  8  latched character
busy  output  1  1 while state != IDLE

Behaviour:
- Reset values:
  - rq_lcd=0, lcd_row=0, lcd_column=0, lcd_char=8'h20 (space).
  - ack_a=ack_b=err_a=err_b=0, busy=0.
  - state=IDLE, last_grant=B, so A wins the first tie. Watchdog counter=0.
- All outputs are registered.
- States: IDLE, BUSY, GAP.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that client.
  - Both req: grant the client != last_grant.
  - On grant, at the same edge: latch that client's row/col/char into lcd_*, rq_lcd<=1, owner<=winner, counter<=0, state<=BUSY.
  - rq_lcd therefore rises 1 cycle after req is sampled.
- BUSY:
  - rq_lcd stays 1 and lcd_* stay frozen, even if the client changes its inputs.
  - Counter increments each cycle.
  - ack_lcd=1: rq_lcd<=0, ack_owner<=1, last_grant<=owner, state<=GAP.
  - ack_lcd=0 and counter==TIMEOUT-1: rq_lcd<=0, ack_owner<=1, err_owner<=1, last_grant<=owner, state<=GAP.
  - ack_lcd and timeout in the same cycle: ack wins, err stays 0.
- GAP:
  - Exactly one cycle; ack_x/err_x clear; state<=IDLE.
  - Requests are not sampled here. Clients drop req on the edge they see ack, so a stale req is never re-granted.
- ack_lcd outside BUSY is ignored, with no effect on any output or state.
- A client withdrawing req during BUSY is not supported. The transaction completes and ack still pulses.
- lcd_* hold their last value after completion and are not cleared.
- Throughput: a single client needs at least 4 cycles per character when the driver acks on the cycle after rq_lcd rises.
- Reset mid-transaction: all state and outputs return to reset values immediately (asynchronous). No ack or err is emitted for the killed transaction.

Test Plan:
1. Reset release, req_a=1, row_a=1, col_a=3, char_a=8'h63; driver acks 2 cycles after rq_lcd rises -> rq_lcd=1 with lcd_row=1, lcd_column=3, lcd_char=8'h63 from the cycle after req; ack_a pulses once; busy falls after GAP; ack_b and err_b stay 0.
2. req_a and req_b asserted on the same cycle (A: col 1, char 8'h4C; B: col 2, char 8'h75) -> A served first, then B after GAP; lcd_column sequence 1 then 2; exactly one ack per client.
3. Both clients request continuously for 6 transactions -> grant order A,B,A,B,A,B; no client is granted twice in a row.
4. TIMEOUT=8, req_b held, driver never acks -> rq_lcd drops after 8 BUSY cycles; ack_b and err_b pulse together for 1 cycle; next tie goes to A.
5. ack_lcd pulsed in IDLE and in GAP -> no output changes. ack_lcd on the exact timeout cycle -> ack_x=1, err_x=0.
6. rst asserted while BUSY with rq_lcd=1 -> rq_lcd=0, lcd_char=8'h20, busy=0 with no clock edge, and no ack emitted. After release with both req high -> A granted.
